f_mul_pipe: RTL and testbench

Parametrised, fully pipelined IEEE-754-style floating-point multiplier. It is the successor to the fixed-width F_Mul unit: exponent and mantissa widths are generic, valid tracking is per operation, rounding is runtime-selectable, and exception flags are reported. It sits in the Versat datapath as a functional unit: one operation accepted per cycle while running, result produced a fixed 4 cycles later.

---
 rtl/f_mul_pipe_if.sv | 24 ++
 rtl/f_mul_pipe.sv | 155 +++++++++++++++
 tb/tb_f_mul_pipe.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/f_mul_pipe_if.sv
// Operand/result bundle for f_mul_pipe: issue side (valid_i, operands, mode, running) and
// result side (valid_o, out0, flags_o).
interface f_mul_pipe_if #(
  parameter int unsigned DATA_W = 32
);
  logic              running;
  logic              valid_i;
  logic              rnd_mode;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic              valid_o;
  logic [DATA_W-1:0] out0;
  logic [3:0]        flags_o;

  modport master (
    output running, valid_i, rnd_mode, in0, in1,
    input  valid_o, out0, flags_o
  );

  modport slave (
    input  running, valid_i, rnd_mode, in0, in1,
    output valid_o, out0, flags_o
  );
endinterface

// File: rtl/f_mul_pipe.sv
// Four-stage pipelined floating-point multiplier with generic exponent/fraction widths,
// RNE/RTZ rounding selected per operation, flush-to-zero inputs and exception flags.
module f_mul_pipe #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 23
) (
  input  logic        clk,
  input  logic        rst,
  f_mul_pipe_if.slave bus
);
  localparam int unsigned DATA_W = 1 + EXP_W + MANT_W;
  localparam int unsigned BIAS   = 2 ** (EXP_W - 1) - 1;
  localparam int unsigned EW     = EXP_W + 2;
  localparam int unsigned SW     = MANT_W + 1;
  localparam int unsigned PW     = 2 * MANT_W + 2;
  localparam int unsigned EMAX   = 2 ** EXP_W - 1;

  localparam logic [DATA_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W - 1){1'b0}}};

  // Control and special-case result travel alongside the arithmetic of each operation.
  typedef struct packed {
    logic              valid;
    logic              rtz;
    logic              sign;
    logic              spec;
    logic              inv;
    logic [DATA_W-1:0] spec_res;
    logic [EW-1:0]     esum;
  } ctrl_t;

  ctrl_t             s1_ctrl_d, s1_ctrl_q, s2_ctrl_d, s2_ctrl_q, s3_ctrl_d, s3_ctrl_q;
  logic [SW-1:0]     s1_siga_d, s1_siga_q, s1_sigb_d, s1_sigb_q;
  logic [PW-1:0]     s2_prod_d, s2_prod_q;
  logic [MANT_W-1:0] s3_frac_d, s3_frac_q;
  logic              s3_guard_d, s3_guard_q, s3_sticky_d, s3_sticky_q;
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] out0_d, out0_q;
  logic [3:0]        flags_d, flags_q;

  logic              sa, sb, za, zb, ia, ib, na, nb;
  logic [EXP_W-1:0]  ea, eb;
  logic [MANT_W-1:0] fa, fb;
  logic [PW-2:0]     norm;
  logic              inc, ovf, unf;
  logic [SW-1:0]     mant;
  logic [EW-1:0]     esum_f;

  // S1: unpack and classify; subnormals count as zero.
  always_comb begin
    {sa, ea, fa} = bus.in0;
    {sb, eb, fb} = bus.in1;
    za = (ea == '0);
    zb = (eb == '0);
    ia = (&ea) && (fa == '0);
    ib = (&eb) && (fb == '0);
    na = (&ea) && (fa != '0);
    nb = (&eb) && (fb != '0);

    s1_ctrl_d.valid    = bus.valid_i;
    s1_ctrl_d.rtz      = bus.rnd_mode;
    s1_ctrl_d.sign     = sa ^ sb;
    s1_ctrl_d.esum     = {2'b00, ea} + {2'b00, eb} - EW'(BIAS);
    s1_ctrl_d.spec     = 1'b1;
    s1_ctrl_d.inv      = 1'b0;
    s1_ctrl_d.spec_res = QNAN;
    s1_siga_d          = {1'b1, fa};
    s1_sigb_d          = {1'b1, fb};

    if (na || nb) begin
      s1_ctrl_d.spec_res = QNAN;
    end else if ((ia && zb) || (ib && za)) begin
      s1_ctrl_d.inv = 1'b1;
    end else if (ia || ib) begin
      s1_ctrl_d.spec_res = {s1_ctrl_d.sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (za || zb) begin
      s1_ctrl_d.spec_res = {s1_ctrl_d.sign, {(DATA_W - 1){1'b0}}};
    end else begin
      s1_ctrl_d.spec = 1'b0;
    end
  end

  // S2: full significand product.
  always_comb begin
    s2_ctrl_d = s1_ctrl_q;
    s2_prod_d = PW'(s1_siga_q) * PW'(s1_sigb_q);
  end

  // S3: align the leading one to the top of norm, then split off guard and sticky.
  always_comb begin
    s3_ctrl_d      = s2_ctrl_q;
    norm           = s2_prod_q[PW-1] ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
    s3_ctrl_d.esum = s2_ctrl_q.esum + EW'(s2_prod_q[PW-1]);
    s3_frac_d      = norm[PW-2 -: MANT_W];
    s3_guard_d     = norm[MANT_W];
    s3_sticky_d    = |norm[MANT_W-1:0];
  end

  // S4: round, range check, pack.
  always_comb begin
    inc     = !s3_ctrl_q.rtz && s3_guard_q && (s3_sticky_q || s3_frac_q[0]);
    mant    = {1'b0, s3_frac_q} + SW'(inc);
    esum_f  = s3_ctrl_q.esum + EW'(mant[MANT_W]);
    ovf     = !esum_f[EW-1] && (esum_f >= EW'(EMAX));
    unf     = esum_f[EW-1] || (esum_f == '0);
    valid_d = s3_ctrl_q.valid;
    if (s3_ctrl_q.spec) begin
      out0_d  = s3_ctrl_q.spec_res;
      flags_d = {s3_ctrl_q.inv, 3'b000};
    end else if (ovf) begin
      out0_d  = s3_ctrl_q.rtz ? {s3_ctrl_q.sign, {(EXP_W - 1){1'b1}}, 1'b0, {MANT_W{1'b1}}}
                              : {s3_ctrl_q.sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      flags_d = 4'b0101;
    end else if (unf) begin
      out0_d  = {s3_ctrl_q.sign, {(DATA_W - 1){1'b0}}};
      flags_d = 4'b0011;
    end else begin
      out0_d  = {s3_ctrl_q.sign, esum_f[EXP_W-1:0], mant[MANT_W-1:0]};
      flags_d = {3'b000, s3_guard_q | s3_sticky_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_ctrl_q   <= '0;
      s1_siga_q   <= '0;
      s1_sigb_q   <= '0;
      s2_ctrl_q   <= '0;
      s2_prod_q   <= '0;
      s3_ctrl_q   <= '0;
      s3_frac_q   <= '0;
      s3_guard_q  <= 1'b0;
      s3_sticky_q <= 1'b0;
      valid_q     <= 1'b0;
      out0_q      <= '0;
      flags_q     <= '0;
    end else if (bus.running) begin
      s1_ctrl_q   <= s1_ctrl_d;
      s1_siga_q   <= s1_siga_d;
      s1_sigb_q   <= s1_sigb_d;
      s2_ctrl_q   <= s2_ctrl_d;
      s2_prod_q   <= s2_prod_d;
      s3_ctrl_q   <= s3_ctrl_d;
      s3_frac_q   <= s3_frac_d;
      s3_guard_q  <= s3_guard_d;
      s3_sticky_q <= s3_sticky_d;
      valid_q     <= valid_d;
      out0_q      <= out0_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.out0    = out0_q;
  assign bus.flags_o = flags_q;
endmodule

// File: tb/tb_f_mul_pipe.sv
// Bench for f_mul_pipe: FP32 and FP16 instances driven side by side, checked every cycle
// against an arithmetic reference feeding a three-slot delay line per instance.
module tb_f_mul_pipe;
  logic clk;
  logic rst;

  f_mul_pipe_if #(.DATA_W(32)) b32 ();
  f_mul_pipe_if #(.DATA_W(16)) b16 ();

  f_mul_pipe #(.EXP_W(8), .MANT_W(23)) u_dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  f_mul_pipe #(.EXP_W(5), .MANT_W(10)) u_dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  // Reference model state: ops in flight and what the outputs must show.
  logic            sl_v [2][3];
  longint unsigned sl_r [2][3];
  logic [3:0]      sl_f [2][3];
  logic            exp_v [2];
  longint unsigned exp_r [2];
  logic [3:0]      exp_f [2];
  bit              exp_rst [2];

  task automatic chk(input string name, input int d, input longint unsigned got,
                     input longint unsigned want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %h want %h", name, d, $time, got, want);
    end
  endtask

  function automatic void ref_mul(input int ew, input int mw, input longint unsigned a,
                                  input longint unsigned b, input bit rtz,
                                  output longint unsigned r, output logic [3:0] f);
    longint unsigned emask, fmask, ea, eb, fa, fb, s, inf, zero, qnan, p, q, rem, half;
    int bias, e, sh;
    bit nan_a, nan_b, inf_a, inf_b, z_a, z_b, inexact;
    emask = (64'd1 << ew) - 1;
    fmask = (64'd1 << mw) - 1;
    bias  = (1 << (ew - 1)) - 1;
    s     = ((a >> (ew + mw)) ^ (b >> (ew + mw))) & 64'd1;
    ea    = (a >> mw) & emask;
    eb    = (b >> mw) & emask;
    fa    = a & fmask;
    fb    = b & fmask;
    qnan  = (emask << mw) | (64'd1 << (mw - 1));
    inf   = (s << (ew + mw)) | (emask << mw);
    zero  = s << (ew + mw);
    nan_a = (ea == emask) && (fa != 0);
    nan_b = (eb == emask) && (fb != 0);
    inf_a = (ea == emask) && (fa == 0);
    inf_b = (eb == emask) && (fb == 0);
    z_a   = (ea == 0);
    z_b   = (eb == 0);
    f     = 4'b0000;
    if (nan_a || nan_b) r = qnan;
    else if ((inf_a && z_b) || (inf_b && z_a)) begin
      r = qnan;
      f = 4'b1000;
    end else if (inf_a || inf_b) r = inf;
    else if (z_a || z_b) r = zero;
    else begin
      p  = ((64'd1 << mw) | fa) * ((64'd1 << mw) | fb);
      e  = int'(ea) + int'(eb) - bias;
      sh = mw;
      if ((p >> (2 * mw + 1)) != 0) begin
        sh = mw + 1;
        e++;
      end
      q       = p >> sh;
      rem     = p & ((64'd1 << sh) - 1);
      half    = 64'd1 << (sh - 1);
      inexact = (rem != 0);
      if (!rtz && (rem > half || (rem == half && q[0]))) q++;
      if ((q >> (mw + 1)) != 0) begin
        q = q >> 1;
        e++;
      end
      if (e >= int'(emask)) begin
        r = rtz ? ((s << (ew + mw)) | ((emask - 1) << mw) | fmask) : inf;
        f = 4'b0101;
      end else if (e <= 0) begin
        r = zero;
        f = 4'b0011;
      end else begin
        r = (s << (ew + mw)) | (longint'(e) << mw) | (q & fmask);
        f = {3'b000, inexact};
      end
    end
  endfunction

  task automatic pin(input string name, input int ew, input int mw, input longint unsigned a,
                     input longint unsigned b, input bit rtz, input longint unsigned wr,
                     input logic [3:0] wf);
    longint unsigned r;
    logic [3:0] f;
    ref_mul(ew, mw, a, b, rtz, r, f);
    chk({name, "_res"}, 9, r, wr);
    chk({name, "_flg"}, 9, 64'(f), 64'(wf));
  endtask

  // Advance one clock edge and update the model with the inputs sampled at that edge.
  task automatic tick();
    logic            run [2];
    logic            vi [2];
    logic            rm [2];
    longint unsigned ia [2];
    longint unsigned ib [2];
    longint unsigned r;
    logic [3:0]      f;
    @(posedge clk);
    run[0] = b32.running; vi[0] = b32.valid_i; rm[0] = b32.rnd_mode;
    ia[0] = 64'(b32.in0); ib[0] = 64'(b32.in1);
    run[1] = b16.running; vi[1] = b16.valid_i; rm[1] = b16.rnd_mode;
    ia[1] = 64'(b16.in0); ib[1] = 64'(b16.in1);
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        for (int s = 0; s < 3; s++) sl_v[d][s] = 1'b0;
        exp_v[d] = 1'b0; exp_r[d] = 0; exp_f[d] = 4'b0; exp_rst[d] = 1'b1;
      end else if (run[d]) begin
        exp_v[d] = sl_v[d][2]; exp_r[d] = sl_r[d][2]; exp_f[d] = sl_f[d][2];
        exp_rst[d] = 1'b0;
        for (int s = 2; s > 0; s--) begin
          sl_v[d][s] = sl_v[d][s-1]; sl_r[d][s] = sl_r[d][s-1]; sl_f[d][s] = sl_f[d][s-1];
        end
        if (d == 0) ref_mul(8, 23, ia[d], ib[d], rm[d], r, f);
        else ref_mul(5, 10, ia[d], ib[d], rm[d], r, f);
        sl_v[d][0] = vi[d]; sl_r[d][0] = r; sl_f[d][0] = f;
      end
    end
    started = 1'b1;
    #1;
  endtask

  task automatic set_op(input int d, input bit v, input longint unsigned a,
                        input longint unsigned b, input bit m);
    if (d == 0) begin
      b32.valid_i = v; b32.in0 = a[31:0]; b32.in1 = b[31:0]; b32.rnd_mode = m;
    end else begin
      b16.valid_i = v; b16.in0 = a[15:0]; b16.in1 = b[15:0]; b16.rnd_mode = m;
    end
  endtask

  function automatic longint unsigned rand_op(input int ew, input int mw);
    longint unsigned emask, fmask, s, e, f;
    int bias, k;
    emask = (64'd1 << ew) - 1;
    fmask = (64'd1 << mw) - 1;
    bias  = (1 << (ew - 1)) - 1;
    k     = int'($urandom_range(0, 15));
    s     = 64'($urandom_range(0, 1));
    f     = {$urandom, $urandom} & fmask;
    case (k)
      0: begin e = 0; f = 0; end
      1: begin e = 0; f = f | 64'd1; end
      2: begin e = emask; f = 0; end
      3: begin e = emask; f = f | 64'd1; end
      4: e = 64'($urandom_range(1, 32'(emask) - 1));
      5: e = emask - 1;
      default: e = 64'($urandom_range(32'(bias / 2), 32'(bias + bias / 2)));
    endcase
    return (s << (ew + mw)) | (e << mw) | f;
  endfunction

  // Compare process: every falling edge, both instances against the model.
  initial begin
    wait (started);
    forever begin
      @(negedge clk);
      chk("valid_o", 0, 64'(b32.valid_o), 64'(exp_v[0]));
      chk("valid_o", 1, 64'(b16.valid_o), 64'(exp_v[1]));
      if (exp_v[0]) begin
        chk("out0", 0, 64'(b32.out0), exp_r[0]);
        chk("flags_o", 0, 64'(b32.flags_o), 64'(exp_f[0]));
      end
      if (exp_v[1]) begin
        chk("out0", 1, 64'(b16.out0), exp_r[1]);
        chk("flags_o", 1, 64'(b16.flags_o), 64'(exp_f[1]));
      end
      if (exp_rst[0]) begin
        chk("rst_out0", 0, 64'(b32.out0), 0);
        chk("rst_flags", 0, 64'(b32.flags_o), 0);
      end
      if (exp_rst[1]) begin
        chk("rst_out0", 1, 64'(b16.out0), 0);
        chk("rst_flags", 1, 64'(b16.flags_o), 0);
      end
    end
  end

  longint unsigned va [13] = '{64'h3FC00000, 64'hBFC00000, 64'h3F800001, 64'h3F800001,
                               64'h7F7FFFFF, 64'h7F7FFFFF, 64'h00800000, 64'h7F800000,
                               64'h80000000, 64'h00000001, 64'hFFC00001, 64'h7F800000,
                               64'h7F000000};
  longint unsigned vb [13] = '{64'h40000000, 64'h40000000, 64'h3FC00000, 64'h3FC00000,
                               64'h40000000, 64'h40000000, 64'h3F000000, 64'h00000000,
                               64'h3F800000, 64'h3F800000, 64'h3F800000, 64'hC0000000,
                               64'h7F000000};
  bit              vm [13] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    // Pin the reference model to hand-computed results.
    pin("basic", 8, 23, 64'h3FC00000, 64'h40000000, 0, 64'h40400000, 4'b0000);
    pin("neg", 8, 23, 64'hBFC00000, 64'h40000000, 0, 64'hC0400000, 4'b0000);
    pin("tie_rne", 8, 23, 64'h3F800001, 64'h3FC00000, 0, 64'h3FC00002, 4'b0001);
    pin("tie_rtz", 8, 23, 64'h3F800001, 64'h3FC00000, 1, 64'h3FC00001, 4'b0001);
    pin("ovf_rne", 8, 23, 64'h7F7FFFFF, 64'h40000000, 0, 64'h7F800000, 4'b0101);
    pin("ovf_rtz", 8, 23, 64'h7F7FFFFF, 64'h40000000, 1, 64'h7F7FFFFF, 4'b0101);
    pin("unf", 8, 23, 64'h00800000, 64'h3F000000, 0, 64'h00000000, 4'b0011);
    pin("inf_zero", 8, 23, 64'h7F800000, 64'h00000000, 0, 64'h7FC00000, 4'b1000);
    pin("negzero", 8, 23, 64'h80000000, 64'h3F800000, 0, 64'h80000000, 4'b0000);
    pin("subn", 8, 23, 64'h00000001, 64'h3F800000, 0, 64'h00000000, 4'b0000);
    pin("fp16", 5, 10, 64'h3E00, 64'h4000, 0, 64'h4200, 4'b0000);

    rst = 1'b0;
    b32.running = 1'b1;
    b16.running = 1'b1;
    set_op(0, 0, 0, 0, 0);
    set_op(1, 0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b1;

    // Single pulse: result must appear exactly four advancing edges later.
    set_op(0, 1, 64'h3FC00000, 64'h40000000, 0);
    tick();
    set_op(0, 0, 0, 0, 0);
    repeat (6) tick();

    // Directed vectors back-to-back, including mixed rounding modes.
    for (int i = 0; i < 13; i++) begin
      set_op(0, 1, va[i], vb[i], vm[i]);
      tick();
    end
    set_op(0, 0, 0, 0, 0);
    repeat (6) tick();

    // Random traffic on both instances with bubbles and random stalls.
    for (int i = 0; i < 400; i++) begin
      set_op(0, $urandom_range(0, 9) < 8, rand_op(8, 23), rand_op(8, 23), 1'($urandom));
      set_op(1, $urandom_range(0, 9) < 8, rand_op(5, 10), rand_op(5, 10), 1'($urandom));
      b32.running = ($urandom_range(0, 6) != 0);
      b16.running = ($urandom_range(0, 6) != 0);
      tick();
    end
    b32.running = 1'b1;
    b16.running = 1'b1;
    set_op(0, 0, 0, 0, 0);
    set_op(1, 0, 0, 0, 0);
    repeat (6) tick();

    // Stream with a valid gap and a three-cycle stall mid-stream.
    for (int i = 0; i < 9; i++) begin
      set_op(0, i != 6, rand_op(8, 23), rand_op(8, 23), 1'($urandom));
      if (i == 4) begin
        b32.running = 1'b0;
        repeat (3) tick();
        b32.running = 1'b1;
      end
      tick();
    end
    set_op(0, 0, 0, 0, 0);
    repeat (6) tick();

    // Reset with three operations in flight on both instances.
    for (int i = 0; i < 3; i++) begin
      set_op(0, 1, rand_op(8, 23), rand_op(8, 23), 0);
      set_op(1, 1, rand_op(5, 10), rand_op(5, 10), 0);
      tick();
    end
    set_op(0, 0, 0, 0, 0);
    set_op(1, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (6) tick();

    set_op(1, 1, 64'h3E00, 64'h4000, 0);
    tick();
    set_op(1, 0, 0, 0, 0);
    repeat (6) tick();

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
